// File: rtl/trapezoid_integrator.sv
// Windowed accumulator for trapezoid surface samples: sums num_segments samples, then holds the result until downstream handshake.
// Optional feature: define TRAP_INTEG_SAT_EN for a saturating accumulator with sticky overflow flag.
module trapezoid_integrator #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_segments,
    input  logic [31:0]      surf_in,
    input  logic             surf_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] integral,
    output logic             integral_valid,
    output logic             busy,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] num_lat;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept_start;
    logic             sample_acc;
    logic             last_sample;

`ifdef TRAP_INTEG_SAT_EN
    logic             ovf;
    logic [ACC_W:0]   sum_ext;

    // Full-width sum; the extra top bit is the carry-out that triggers saturation.
    function automatic logic [ACC_W:0] add_sample(input logic [ACC_W-1:0] a, input logic [31:0] s);
        return {1'b0, a} + (ACC_W+1)'(s);
    endfunction

    function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W:0] sum);
        return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    endfunction

    assign sum_ext  = add_sample(acc, surf_in);
    assign overflow = ovf;
`else
    function automatic logic [ACC_W-1:0] add_sample(input logic [ACC_W-1:0] a, input logic [31:0] s);
        return a + ACC_W'(s);
    endfunction

    assign overflow = 1'b0;
`endif

    assign accept_start = (state == IDLE) && start;
    assign sample_acc   = (state == ACCUM) && surf_valid;
    assign cnt_inc      = cnt + CNT_W'(1);
    assign last_sample  = sample_acc && (cnt_inc == num_lat);

    assign integral       = acc;
    assign integral_valid = (state == HOLD);
    assign busy           = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    // An empty window produces an immediate zero result.
                    state_nxt = (num_segments == '0) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (last_sample) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            num_lat <= '0;
        end else if (accept_start) begin
            acc     <= '0;
            cnt     <= '0;
            num_lat <= num_segments;
        end else if (sample_acc) begin
`ifdef TRAP_INTEG_SAT_EN
            acc     <= sat_acc(sum_ext);
`else
            acc     <= add_sample(acc, surf_in);
`endif
            cnt     <= cnt_inc;
        end
    end

`ifdef TRAP_INTEG_SAT_EN
    // Overflow is sticky for the remainder of the window; cleared only by a new window or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (accept_start) begin
            ovf <= 1'b0;
        end else if (sample_acc && sum_ext[ACC_W]) begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_trapezoid_integrator.sv
// Scoreboard bench for trapezoid_integrator: directed windows push expected results, a monitor checks each handshake.
module tb_trapezoid_integrator;

    localparam int ACC_W = 33;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] num_segments;
    logic [31:0]      surf_in;
    logic             surf_valid;
    logic             out_ready;
    logic [ACC_W-1:0] integral;
    logic             integral_valid;
    logic             busy;
    logic             overflow;

    typedef struct {
        logic [ACC_W-1:0] value;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    trapezoid_integrator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .num_segments   (num_segments),
        .surf_in        (surf_in),
        .surf_valid     (surf_valid),
        .out_ready      (out_ready),
        .integral       (integral),
        .integral_valid (integral_valid),
        .busy           (busy),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [ACC_W-1:0] v, input logic o);
        exp_t e;
        e.value = v;
        e.ovf   = o;
        exp_q.push_back(e);
    endtask

    task automatic start_win(input int n);
        start        = 1'b1;
        num_segments = CNT_W'(n);
        cycle();
        start        = 1'b0;
    endtask

    task automatic send(input logic [31:0] v);
        surf_valid = 1'b1;
        surf_in    = v;
        cycle();
        surf_valid = 1'b0;
    endtask

    // Monitor: every accepted result is compared against the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && integral_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got 0x%0h expected none", integral);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result_integral", 64'(integral), 64'(e.value));
                chk("result_overflow", 64'(overflow), 64'(e.ovf));
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        num_segments = '0;
        surf_in      = '0;
        surf_valid   = 1'b0;
        out_ready    = 1'b1;
        #23;
        chk("reset_integral", 64'(integral), 64'd0);
        chk("reset_valid", 64'(integral_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Four consecutive samples, 1-cycle result latency
        push_exp(33'd80, 1'b0);
        start_win(4);
        chk("w1_busy_after_start", 64'(busy), 64'd1);
        send(32'd8);
        send(32'd16);
        chk("w1_busy_mid", 64'(busy), 64'd1);
        send(32'd24);
        send(32'd32);
        chk("w1_valid_after_last", 64'(integral_valid), 64'd1);
        chk("w1_busy_hold", 64'(busy), 64'd1);
        cycle();
        chk("w1_idle_after_handshake", 64'(busy), 64'd0);

        // Gapped samples, result held under backpressure
        out_ready = 1'b0;
        push_exp(33'd600, 1'b0);
        start_win(3);
        send(32'd100);
        cycle();
        cycle();
        chk("w2_valid_during_gap", 64'(integral_valid), 64'd0);
        send(32'd200);
        send(32'd300);
        for (int i = 0; i < 5; i++) begin
            chk("w2_hold_integral", 64'(integral), 64'd600);
            chk("w2_hold_valid", 64'(integral_valid), 64'd1);
            cycle();
        end
        out_ready = 1'b1;
        cycle();
        chk("w2_valid_dropped", 64'(integral_valid), 64'd0);

        // Empty window
        push_exp(33'd0, 1'b0);
        start_win(0);
        chk("w3_valid_next_cycle", 64'(integral_valid), 64'd1);
        chk("w3_integral_zero", 64'(integral), 64'd0);
        cycle();

        // Start and samples outside IDLE/ACCUM rules are ignored
        out_ready = 1'b0;
        push_exp(33'd30, 1'b0);
        start_win(2);
        start        = 1'b1;
        num_segments = 16'd7;
        send(32'd10);
        start = 1'b0;
        send(32'd20);
        chk("w4_hold_after_two", 64'(integral_valid), 64'd1);
        start = 1'b1;
        surf_valid = 1'b1;
        surf_in = 32'd999;
        cycle();
        cycle();
        chk("w4_hold_unchanged", 64'(integral), 64'd30);
        out_ready = 1'b1;
        cycle();
        chk("w4_no_restart_on_handshake", 64'(busy), 64'd0);
        start      = 1'b0;
        surf_valid = 1'b0;
        cycle();

        // Saturation / wrap at ACC_W=33
        push_exp(
`ifdef TRAP_INTEG_SAT_EN
            33'h1_FFFF_FFFF, 1'b1
`else
            33'h0_FFFF_FFFD, 1'b0
`endif
        );
        start_win(3);
        send(32'hFFFF_FFFF);
        send(32'hFFFF_FFFF);
        send(32'hFFFF_FFFF);
        cycle();

        // Reset mid-window discards the partial sum
        send(32'd77);
        chk("idle_sample_ignored", 64'(busy), 64'd0);
        start_win(4);
        send(32'd1);
        send(32'd2);
        rst_n = 1'b0;
        #1;
        chk("async_reset_busy", 64'(busy), 64'd0);
        chk("async_reset_integral", 64'(integral), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        push_exp(33'd5, 1'b0);
        start_win(1);
        send(32'd5);
        chk("w6_integral", 64'(integral), 64'd5);
        cycle();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            cycle();
        end
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        repeat (3) cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
